// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter. TXDATA writes are queued in a FIFO, and the
// queued bytes are sent 8N1, LSB first, on o_tx. DIVISOR sets the bit period.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_wren,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_data,
  output logic        o_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;
  logic [15:0]      r_div;
  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_shift;
  logic [7:0]       w_shiftNext;
  logic [15:0]      r_period;
  logic [15:0]      r_cnt;
  logic [2:0]       r_bitIdx;
  logic             r_tx;
  logic             w_txNext;

  logic w_mapped;
  logic w_selTx;
  logic w_selStatus;
  logic w_selDiv;
  logic w_txWrite;
  logic w_ovfClear;
  logic w_divWrite;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_bitDone;
  logic w_busy;
  logic w_unused;

  // Only word addresses 0..2 are mapped; any upper address bit set means unmapped.
  assign w_mapped    = (i_addr[29:2] == 28'd0);
  assign w_selTx     = w_mapped && (i_addr[1:0] == 2'd0);
  assign w_selStatus = w_mapped && (i_addr[1:0] == 2'd1);
  assign w_selDiv    = w_mapped && (i_addr[1:0] == 2'd2);

  assign w_txWrite  = i_wren && i_mask[0] && w_selTx;
  assign w_ovfClear = i_wren && i_mask[0] && w_selStatus && i_data[3];
  assign w_divWrite = i_wren && w_selDiv;

  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign w_push    = w_txWrite && !w_full;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_bitDone = (r_cnt == r_period);
  assign w_busy    = (r_state != IDLE);
  assign w_unused  = ^{i_data[31:16], i_mask[3:2]};

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= i_data[7:0];
    end
  end

  // A write into a full FIFO is dropped even if the head pops on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_div   <= 16'(DEFAULT_DIV);
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
      if (w_txWrite && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovfClear) begin
        r_ovf <= 1'b0;
      end
      if (w_divWrite && i_mask[0]) begin
        r_div[7:0] <= i_data[7:0];
      end
      if (w_divWrite && i_mask[1]) begin
        r_div[15:8] <= i_data[15:8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (!w_empty) w_nextState = START;
      START: if (w_bitDone) w_nextState = DATA;
      DATA:  if (w_bitDone && (r_bitIdx == 3'd7)) w_nextState = STOP;
      STOP:  if (w_bitDone) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The line level is derived from the upcoming state so o_tx changes on the same edge.
  always_comb begin
    w_shiftNext = r_shift;
    if (w_pop) begin
      w_shiftNext = r_fifo[r_rptr];
    end else if ((r_state == DATA) && w_bitDone) begin
      w_shiftNext = {1'b0, r_shift[7:1]};
    end
    w_txNext = 1'b1;
    case (w_nextState)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      default: w_txNext = 1'b1;
    endcase
  end

  // The period is latched at pop time so DIVISOR writes never disturb a frame in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift  <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_shift <= w_shiftNext;
      r_tx    <= w_txNext;
      if (w_pop) begin
        r_period <= r_div;
        r_cnt    <= '0;
        r_bitIdx <= '0;
      end else if (r_state != IDLE) begin
        if (w_bitDone) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if ((r_state == DATA) && w_bitDone) begin
          r_bitIdx <= r_bitIdx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_data = '0;
    if (w_selStatus) begin
      o_data = {16'h0, 8'(r_level), 4'h0, r_ovf, w_empty, w_full, w_busy};
    end else if (w_selDiv) begin
      o_data = {16'h0, r_div};
    end
  end

  assign o_tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queued bytes are predicted into a scoreboard and a
// line monitor decodes o_tx sample by sample against the predicted frames.
module tb_mmio_uart_tx;

  localparam int FIFO_DEPTH  = 16;
  localparam int DEFAULT_DIV = 433;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wren = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic        tx;

  int          checks = 0;
  int          failures = 0;
  frame_t      expQ[$];
  logic        modelOvf = 1'b0;
  logic [15:0] modelDiv = 16'(DEFAULT_DIV);
  bit          inFrame = 1'b0;
  int          idleRun = 0;
  int          lastGap = 0;

  mmio_uart_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .i_addr (addr),
    .i_data (wdata),
    .i_wren (wren),
    .i_mask (mask),
    .o_data (rdata),
    .o_tx   (tx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Expected STATUS from the scoreboard: bytes not yet started are the FIFO contents.
  function automatic logic [31:0] modelStatus();
    int lvl;
    lvl = expQ.size();
    return {16'h0, 8'(lvl), 4'h0, modelOvf, (lvl == 0), (lvl == FIFO_DEPTH), inFrame};
  endfunction

  // One bus write; the reference model is updated at the same edge the DUT samples.
  task automatic applyStimulus(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr = a;
    wdata = d;
    mask = m;
    wren = 1'b1;
    @(posedge clk);
    if (a == 30'd0 && m[0]) begin
      if (expQ.size() >= FIFO_DEPTH) modelOvf = 1'b1;
      else expQ.push_back('{data: d[7:0], div: int'(modelDiv)});
    end else if (a == 30'd1 && m[0] && d[3]) begin
      modelOvf = 1'b0;
    end else if (a == 30'd2) begin
      if (m[0]) modelDiv[7:0] = d[7:0];
      if (m[1]) modelDiv[15:8] = d[15:8];
    end
    #1;
    wren = 1'b0;
    mask = '0;
  endtask

  task automatic busRead(input logic [29:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    wren = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic checkStatus(input string name);
    logic [31:0] d;
    busRead(30'd1, d);
    checkOutput(name, d, modelStatus());
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while ((expQ.size() != 0 || inFrame) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic doReset();
    rstN = 1'b0;
    expQ.delete();
    modelOvf = 1'b0;
    modelDiv = 16'(DEFAULT_DIV);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Line monitor: every clock of each frame must show the predicted level.
  initial begin : monitor
    frame_t      e;
    logic [9:0]  bits;
    bit          bad;
    bit          aborted;
    int          badSlot;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        inFrame = 1'b0;
        idleRun = 0;
        continue;
      end
      if (tx === 1'b1) begin
        inFrame = 1'b0;
        idleRun++;
        continue;
      end
      lastGap = idleRun;
      idleRun = 0;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedFrame: got start bit, required idle line");
        continue;
      end
      e = expQ.pop_front();
      inFrame = 1'b1;
      bits = {1'b1, e.data, 1'b0};
      bad = 1'b0;
      aborted = 1'b0;
      badSlot = 0;
      for (int s = 0; s < 10 && !aborted; s++) begin
        for (int k = 0; k <= e.div && !aborted; k++) begin
          if (s != 0 || k != 0) @(negedge clk);
          if (!rstN) aborted = 1'b1;
          else if (tx !== bits[s] && !bad) begin
            bad = 1'b1;
            badSlot = s;
          end
        end
      end
      if (aborted) begin
        inFrame = 1'b0;
      end else begin
        checks++;
        if (bad) begin
          failures++;
          $display("[TB] FAIL frame 0x%02h div %0d: line wrong in bit slot %0d, required 0x%02h LSB first",
                   e.data, e.div, badSlot, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] d;
    int          n;
    logic [15:0] rdiv;

    doReset();
    busRead(30'd1, d);
    checkOutput("resetStatus", d, 32'h0000_0004);
    busRead(30'd2, d);
    checkOutput("resetDivisor", d, 32'd433);
    checkOutput("resetTx", {31'd0, tx}, 32'd1);

    // Single 0x55 frame with 4-clock bits and exact boundary timing.
    applyStimulus(30'd2, 32'd3, 4'b0011);
    applyStimulus(30'd0, 32'h0000_0055, 4'b0001);
    checkOutput("txHighAfterWriteEdge", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("startLatency", {31'd0, tx}, 32'd0);
    repeat (39) @(posedge clk);
    busRead(30'd1, d);
    checkOutput("busyLastStopClock", d, 32'h0000_0005);
    busRead(30'd1, d);
    checkOutput("idleAfterFrame", d, 32'h0000_0004);

    // Overflow: 18 back-to-back bytes, the last one must be dropped.
    applyStimulus(30'd2, 32'd100, 4'b0011);
    for (int i = 0; i < 18; i++) applyStimulus(30'd0, 32'(i), 4'b0001);
    busRead(30'd1, d);
    checkOutput("overflowStatus", d, 32'h0000_100B);
    applyStimulus(30'd1, 32'h8, 4'b0010);
    busRead(30'd1, d);
    checkOutput("ovfKeptWrongLane", {31'd0, d[3]}, 32'd1);
    applyStimulus(30'd1, 32'h8, 4'b0001);
    busRead(30'd1, d);
    checkOutput("ovfClearedW1C", {31'd0, d[3]}, 32'd0);
    checkStatus("drainingStatus");
    waitIdle("drainOverflow", 20000);

    // Partial DIVISOR lane writes, then unmapped accesses.
    applyStimulus(30'd2, 32'd3, 4'b0011);
    applyStimulus(30'd2, 32'h0000_ABCD, 4'b0001);
    busRead(30'd2, d);
    checkOutput("divLowLane", d, 32'h0000_00CD);
    applyStimulus(30'd2, 32'h0000_1200, 4'b0010);
    busRead(30'd2, d);
    checkOutput("divHighLane", d, 32'h0000_12CD);
    applyStimulus(30'd4, 32'h0000_0077, 4'b1111);
    applyStimulus(30'd3, 32'h0000_0077, 4'b1111);
    applyStimulus(30'd0, 32'h0000_0066, 4'b1110);
    busRead(30'd5, d);
    checkOutput("unmappedHighRead", d, 32'd0);
    busRead(30'd3, d);
    checkOutput("unmappedLowRead", d, 32'd0);
    busRead(30'd0, d);
    checkOutput("txdataReadsZero", d, 32'd0);
    checkStatus("noFrameFromIgnoredWrites");

    // Divisor change mid-frame applies only to the next popped byte.
    applyStimulus(30'd2, 32'd3, 4'b0011);
    applyStimulus(30'd0, 32'h0000_00A5, 4'b0001);
    repeat (8) @(posedge clk);
    applyStimulus(30'd2, 32'd1, 4'b0011);
    applyStimulus(30'd0, 32'h0000_003C, 4'b0001);
    waitIdle("drainDivChange", 500);
    checkOutput("backToBackGap", 32'(lastGap), 32'd1);

    // Randomized bursts with random divisors, masks and spacing.
    for (int it = 0; it < 6; it++) begin
      rdiv = (it == 0) ? 16'd0 : 16'($urandom_range(0, 6));
      applyStimulus(30'd2, {16'h0, rdiv}, 4'b0011);
      busRead(30'd2, d);
      checkOutput("randDivisor", d, {16'h0, rdiv});
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        applyStimulus(30'd0, $urandom, 4'($urandom_range(0, 15)));
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      checkStatus("randStatus");
      waitIdle("drainRandom", 2000);
    end

    // Reset during the data bits of a zero byte with three more queued.
    applyStimulus(30'd2, 32'd3, 4'b0011);
    for (int i = 0; i < 4; i++) applyStimulus(30'd0, 32'h0, 4'b0001);
    repeat (4) @(posedge clk);
    #2;
    rstN = 1'b0;
    expQ.delete();
    modelOvf = 1'b0;
    modelDiv = 16'(DEFAULT_DIV);
    #1;
    checkOutput("asyncResetTx", {31'd0, tx}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    repeat (60) @(posedge clk);
    busRead(30'd1, d);
    checkOutput("statusAfterAbort", d, 32'h0000_0004);
    busRead(30'd2, d);
    checkOutput("divisorAfterAbort", d, 32'd433);
    checkOutput("txIdleAfterAbort", {31'd0, tx}, 32'd1);

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter peripheral on the MMIO port of the data-memory crossbar.
- Responds to the CPU's word-addressed MMIO accesses; address is already offset-relative to MMIO start.
- Buffers bytes in a TX FIFO and serialises them 8N1, LSB first, on o_tx.
- Read data is combinational, so the crossbar returns it in the same cycle.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 433, reset value of DIVISOR; bit period = DIVISOR+1 clocks (50 MHz / 115200).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_addr  in  30  word address relative to MMIO base.
- i_data  in  32  write data.
- i_wren  in  1  write strobe, one access per cycle.
- i_mask  in  4  byte-lane enables; bit n covers i_data[8n+7:8n].
- o_data  out  32  read data, combinational from i_addr and current state.
- o_tx  out  1  serial line, idle high.

Behaviour:
- Register map (word address):
  - 0 TXDATA: write with i_wren and i_mask[0] pushes i_data[7:0]; reads 0.
  - 1 STATUS: read bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow, bits[15:8] FIFO level 0..FIFO_DEPTH, others 0. Write with i_mask[0] and i_data[3]=1 clears overflow (W1C); all other bits ignored.
  - 2 DIVISOR: 16-bit R/W in bits[15:0]; i_mask[0] writes bits[7:0], i_mask[1] writes bits[15:8]; reads zero-extended.
  - Any other address: reads 0, writes ignored. Only the low 2 bits of i_addr are decoded when i_addr[29:2]==0; nonzero upper bits mean unmapped.
- Reset (asynchronous, immediate on i_rst_n low): o_tx=1, FSM IDLE, FIFO empty (level 0), overflow=0, DIVISOR=DEFAULT_DIV, all counters 0. Reset mid-frame aborts the frame; o_tx goes high without waiting for a clock.
- FIFO:
  - Push at a clock edge where the TXDATA write is active.
  - If full before that edge, the byte is dropped and overflow is set, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH; level is tracked separately so full and empty are unambiguous.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty at the edge, pop the head, latch the byte into the shift register, latch DIVISOR into the active period, clear the bit counter, and go to START. Otherwise stay.
  - START: o_tx=0 for active period +1 clocks, then go to DATA.
  - DATA: o_tx = shift[0]. Each bit is held active period +1 clocks, then shift right. After 8 bits go to STOP.
  - STOP: o_tx=1 for active period +1 clocks, then go to IDLE.
  - o_tx is registered and set on the same edge as each state or bit change.
- Timing:
  - Latency: TXDATA write at edge N makes the FIFO non-empty after N. IDLE pops at N+1, and o_tx falls after edge N+1.
  - Frame = 10×(DIV+1) clocks. Back-to-back frames are separated by exactly 1 IDLE clock.
- A DIVISOR write during a frame does not affect that frame; it applies from the next pop. DIVISOR=0 is legal and gives 1 clock per bit.
- A push into an empty FIFO in the same cycle IDLE samples it is not popped until the following edge.

Test Plan:
- Reset, then read STATUS and DIVISOR -> STATUS=0x00000004, DIVISOR=433, o_tx=1.
- Write DIVISOR=3, then TXDATA=0x55 -> o_tx falls one clock after the write edge. Line reads 0,1,0,1,0,1,0,1,0,1, each 4 clocks. Busy=1 throughout; after 41 clocks STATUS=0x00000004 again.
- With DIVISOR=100, write 18 bytes 0x00..0x11 back-to-back:
  - The first pops immediately and the next 16 fill the FIFO.
  - The 18th is dropped: STATUS shows full=1, overflow=1, level=16.
  - All 17 accepted bytes transmit in order; 0x11 never appears.
- Write STATUS=0x8 with mask=0001 -> overflow clears. Write 0x8 with mask=0010 -> overflow unchanged.
- DIVISOR=3, send 0xA5, write DIVISOR=1 mid-frame, queue 0x3C -> 0xA5 uses 4-clock bits, one IDLE clock, then 0x3C uses 2-clock bits.
- Drop i_rst_n during the DATA bits of a frame with 3 bytes queued -> o_tx=1 asynchronously. After release: level=0, idle line, no further frames.
